// File: rtl/de0_nano_gpio_pkg.sv
// Shared constants and helpers for the DE0-Nano bidirectional GPIO block.
package de0_nano_gpio_pkg;

   localparam int unsigned BUS_W = 32;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_DIR      = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   // Forces every bus bit at or above the port width to read as zero.
   function automatic logic [BUS_W-1:0] rd_zext(input logic [BUS_W-1:0] value,
                                                input int unsigned      width);
      logic [BUS_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < BUS_W; i++) begin
         if (i < width) r[i] = value[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/de0_nano_gpio_sync_edge.sv
// Input synchroniser, previous-value register and armed edge detector for
// the GPIO pins.
module de0_nano_gpio_sync_edge
   import de0_nano_gpio_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = EDGE_ANY
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] sync_in,
   output logic [WIDTH-1:0] edge_pulse
);

   localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
   localparam int unsigned CNT_W      = $clog2(ARM_CYCLES + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  prev_q;
   logic [CNT_W-1:0]                  arm_cnt;
   logic                              armed;
   logic [WIDTH-1:0]                  edge_raw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Keeps detection off until the reset-zeroed pipeline has filled with real pin levels.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm_cnt <= '0;
      end else if (!armed) begin
         arm_cnt <= arm_cnt + CNT_W'(1);
      end
   end

   assign armed   = (arm_cnt == CNT_W'(ARM_CYCLES));
   assign sync_in = sync_q[SYNC_STAGES-1];

   if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edge_raw = sync_in & ~prev_q;
   end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_raw = ~sync_in & prev_q;
   end else begin : g_any
      assign edge_raw = sync_in ^ prev_q;
   end

   assign edge_pulse = armed ? edge_raw : '0;

endmodule

// File: rtl/de0_nano_system_gpio_bidir.sv
// Avalon-MM bidirectional GPIO port with per-pin direction, optional
// open-drain drive, edge capture and maskable level interrupt.
module de0_nano_system_gpio_bidir
   import de0_nano_gpio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      EDGE_TYPE   = EDGE_ANY,
   parameter logic [WIDTH-1:0] RESET_OUT   = '1,
   parameter logic [WIDTH-1:0] OD_MASK     = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [BUS_W-1:0]  writedata,
   output logic [BUS_W-1:0]  readdata,
   inout  wire  [WIDTH-1:0]  bidir_port,
   output logic              irq
);

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   logic [WIDTH-1:0] data_out, data_out_nxt;
   logic [WIDTH-1:0] data_dir, dir_nxt;
   logic [WIDTH-1:0] irq_mask, mask_nxt;
   logic [WIDTH-1:0] edge_cap, cap_nxt, cap_clr;
   logic [WIDTH-1:0] rd_sel;

   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] edge_pulse;

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   de0_nano_gpio_sync_edge #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .pin_in     (bidir_port),
      .sync_in    (sync_in),
      .edge_pulse (edge_pulse)
   );

   // Register writes and read-data selection.
   always_comb begin
      data_out_nxt = data_out;
      dir_nxt      = data_dir;
      mask_nxt     = irq_mask;
      cap_clr      = '0;
      rd_sel       = '0;
      if (wr) begin
         case (address)
            ADDR_DATA:     data_out_nxt = wd;
            ADDR_DIR:      dir_nxt      = wd;
            ADDR_IRQ_MASK: mask_nxt     = wd;
            ADDR_EDGE_CAP: cap_clr      = wd;
            ADDR_OUTSET:   data_out_nxt = data_out | wd;
            ADDR_OUTCLR:   data_out_nxt = data_out & ~wd;
            default:       ;
         endcase
      end
      case (address)
         ADDR_DATA:     rd_sel = sync_in;
         ADDR_DIR:      rd_sel = data_dir;
         ADDR_IRQ_MASK: rd_sel = irq_mask;
         ADDR_EDGE_CAP: rd_sel = edge_cap;
         default:       rd_sel = '0;
      endcase
   end

   // A fresh edge outranks a simultaneous clear of the same bit.
   assign cap_nxt = (edge_cap & ~cap_clr) | edge_pulse;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= RESET_OUT;
         data_dir <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         irq      <= 1'b0;
         readdata <= '0;
      end else begin
         data_out <= data_out_nxt;
         data_dir <= dir_nxt;
         irq_mask <= mask_nxt;
         edge_cap <= cap_nxt;
         irq      <= |(edge_cap & irq_mask);
         readdata <= rd_zext(BUS_W'(rd_sel), WIDTH);
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      if (OD_MASK[i]) begin : g_od
         assign bidir_port[i] = (data_dir[i] && !data_out[i]) ? 1'b0 : 1'bz;
      end else begin : g_pp
         assign bidir_port[i] = data_dir[i] ? data_out[i] : 1'bz;
      end
   end

endmodule

// File: tb/tb_de0_nano_system_gpio_bidir.sv
// Scoreboard bench for the bidirectional GPIO: pulled-up pins, an external
// driver on pin 4, register reads checked one cycle after issue.
module tb_de0_nano_system_gpio_bidir;
   import de0_nano_gpio_pkg::*;

   localparam int unsigned WIDTH = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [2:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;
   wire  [WIDTH-1:0]  pins;

   logic ext_en;
   logic ext_val;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   for (genvar i = 0; i < WIDTH; i++) begin : g_pull
      pullup pu (pins[i]);
   end

   assign pins[4] = ext_en ? ext_val : 1'bz;

   de0_nano_system_gpio_bidir #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2),
      .EDGE_TYPE   (EDGE_RISE),
      .RESET_OUT   (8'hFF),
      .OD_MASK     (8'h01)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .bidir_port (pins),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input string tag, input logic [2:0] a, input logic [31:0] e);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      tick();
      chipselect = 1'b0;
      check(tag_q.pop_front(), readdata, exp_q.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      ext_en     = 1'b0;
      ext_val    = 1'b0;
      #1;
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_pins", 32'(pins), 32'hFF);
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (5) tick();

      // Register sweep with all pins pulled high: no spurious capture.
      bus_read("rd_data", ADDR_DATA, 32'hFF);
      bus_read("rd_dir", ADDR_DIR, 32'h0);
      bus_read("rd_mask", ADDR_IRQ_MASK, 32'h0);
      bus_read("rd_cap_arm", ADDR_EDGE_CAP, 32'h0);
      bus_read("rd_outset", ADDR_OUTSET, 32'h0);
      bus_read("rd_outclr", ADDR_OUTCLR, 32'h0);
      bus_read("rd_addr6", 3'd6, 32'h0);
      bus_read("rd_addr7", 3'd7, 32'h0);
      check("irq_idle", 32'(irq), 32'h0);

      // Push-pull low nibble, then bit set/clear helpers.
      bus_write(ADDR_DIR, 32'h0F);
      bus_write(ADDR_DATA, 32'hFFFF_FFA5);
      check("pins_a5", 32'(pins), 32'hF5);
      bus_write(ADDR_OUTSET, 32'h02);
      bus_write(ADDR_OUTCLR, 32'h01);
      check("pins_set_clr", 32'(pins), 32'hF6);
      repeat (3) tick();
      bus_read("rd_data_f6", ADDR_DATA, 32'hF6);
      bus_read("rd_dir_0f", ADDR_DIR, 32'h0F);
      bus_read("rd_cap_own", ADDR_EDGE_CAP, 32'h02);
      bus_write(ADDR_EDGE_CAP, 32'hFF);
      bus_read("rd_cap_clr", ADDR_EDGE_CAP, 32'h0);

      // Open-drain bit 0: driven low or released.
      bus_write(ADDR_DIR, 32'h01);
      check("od_low", 32'(pins), 32'hFE);
      bus_write(ADDR_DATA, 32'h01);
      check("od_release", 32'(pins), 32'hFF);
      repeat (3) tick();
      bus_read("rd_cap_od", ADDR_EDGE_CAP, 32'h09);
      bus_write(ADDR_EDGE_CAP, 32'hFF);
      bus_read("rd_cap_od_clr", ADDR_EDGE_CAP, 32'h0);

      // External rising edge on pin 4 with exact capture/irq latency.
      bus_write(ADDR_DIR, 32'h00);
      ext_en  = 1'b1;
      ext_val = 1'b0;
      repeat (4) tick();
      bus_read("rd_cap_fall", ADDR_EDGE_CAP, 32'h0);
      bus_write(ADDR_IRQ_MASK, 32'h10);
      ext_val = 1'b1;
      tick();
      tick();
      bus_read("rd_cap_early", ADDR_EDGE_CAP, 32'h0);
      check("irq_before", 32'(irq), 32'h0);
      bus_read("rd_cap_rise", ADDR_EDGE_CAP, 32'h10);
      check("irq_assert", 32'(irq), 32'h1);
      bus_write(ADDR_EDGE_CAP, 32'h10);
      check("irq_hold", 32'(irq), 32'h1);
      tick();
      check("irq_deassert", 32'(irq), 32'h0);
      bus_read("rd_cap_w1c", ADDR_EDGE_CAP, 32'h0);

      // Edge arriving in the same cycle as a clear of that bit.
      ext_val = 1'b0;
      repeat (4) tick();
      ext_val = 1'b1;
      repeat (4) tick();
      check("irq_rearm", 32'(irq), 32'h1);
      ext_val = 1'b0;
      repeat (4) tick();
      ext_val = 1'b1;
      tick();
      tick();
      bus_write(ADDR_EDGE_CAP, 32'h10);
      tick();
      check("irq_set_wins", 32'(irq), 32'h1);
      bus_read("rd_cap_set_wins", ADDR_EDGE_CAP, 32'h10);

      // Asynchronous reset while all pins are outputs.
      ext_en = 1'b0;
      bus_write(ADDR_DIR, 32'hFF);
      check("pins_all_out", 32'(pins), 32'h01);
      check("irq_pre_reset", 32'(irq), 32'h1);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_pins", 32'(pins), 32'hFF);
      check("mid_rst_irq", 32'(irq), 32'h0);
      check("mid_rst_readdata", readdata, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      repeat (5) tick();
      bus_read("post_rst_data", ADDR_DATA, 32'hFF);
      bus_read("post_rst_dir", ADDR_DIR, 32'h0);
      bus_read("post_rst_mask", ADDR_IRQ_MASK, 32'h0);
      bus_read("post_rst_cap", ADDR_EDGE_CAP, 32'h0);
      check("post_rst_irq", 32'(irq), 32'h0);

      check("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
